nf10_axis_rec_arbiter: RTL
==========================

Name: nf10_axis_rec_arbiter

Overview:
Packet-granular round-robin arbiter that shares one AXI4-Stream sink (typically the simulation recorder or a single output port) among four AXI4-Stream masters. It selects one input and forwards that whole packet (tdata/tstrb/tuser/tlast) unmodified. It then rotates priority. It also keeps packet statistics and exposes the current grant for debug.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width.
C_TIMEOUT_CYCLES, 1024, stall limit in cycles for the optional watchdog; range 2..65535.

Ports:
aclk  in  1  clock, all logic on the rising edge
aresetn  in  1  synchronous active-low reset
s_axis_N_tdata  in  C_AXIS_DATA_WIDTH  input stream N data, N=0..3
s_axis_N_tstrb  in  C_AXIS_DATA_WIDTH/8  input N byte strobes
s_axis_N_tuser  in  C_AXIS_TUSER_WIDTH  input N sideband
s_axis_N_tvalid  in  1  input N valid
s_axis_N_tlast  in  1  input N end of packet
s_axis_N_tready  out  1  input N ready
m_axis_tdata/tstrb/tuser  out  as above  forwarded beat
m_axis_tvalid  out  1  forwarded valid
m_axis_tlast  out  1  forwarded end of packet
m_axis_tready  in  1  sink ready
grant  out  2  index of the input currently owning the output
busy  out  1  high while a packet is in flight (state SEND)
pkt_count  out  32  total packets forwarded, wraps modulo 2^32
timeout_err  out  1  sticky watchdog flag; tied 0 when the optional feature is absent

Behaviour:
- Reset when aresetn=0 at a clock edge:
  - state=IDLE, rr_ptr=0, grant=0, busy=0, pkt_count=0, timeout_err=0.
  - All s_axis_N_tready=0 and m_axis_tvalid=0 from the following cycle.
  - Reset mid-packet abandons the packet. There is no flush; the remainder of the source packet is arbitrated as a new packet after reset.
- States IDLE, SEND.
  - IDLE:
    - All treadys=0 and m_axis_tvalid=0.
    - If any s_axis_N_tvalid=1, pick the first valid input scanning rr_ptr, rr_ptr+1, ... mod 4.
    - Register grant and go to SEND.
    - No valid input: remain in IDLE.
  - SEND: combinational pass-through from input grant.
    - m_axis_* = s_axis_grant_*.
    - s_axis_grant_tready = m_axis_tready.
    - Other treadys = 0.
    - Beat transfers when m_axis_tvalid & m_axis_tready.
    - On a transfer with tlast=1: go to IDLE, rr_ptr=grant+1 mod 4, pkt_count+1.
- Latency:
  - Zero-cycle data path in SEND; no pipeline registers on data.
  - One idle arbitration cycle between consecutive packets; maximum throughput is L/(L+1) for L-beat packets.
- Handshake:
  - tvalid low on the granted input mid-packet holds the grant; no re-arbitration before tlast.
  - m_axis_tready low stalls the source; output data equals the source data, which AXI requires the source to hold stable.
- Single-beat packet (tlast on the first beat): SEND lasts one cycle when the sink is ready.
- Fairness: a continuously requesting input waits at most 3 packets.
- grant is not updated while in SEND.

Optional Feature:
Macro AXIS_REC_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter increments each SEND cycle with no transfer.
  - The counter clears on any transfer and in IDLE.
  - Reaching C_TIMEOUT_CYCLES sets timeout_err, which is sticky until reset. Arbitration is unchanged.
- Undefined: counter logic is absent and timeout_err is constant 0.

Decomposition:
- Package nf10_axis_rec_arb_pkg holds:
  - NUM_PORTS=4
  - PORT_IDX_W=2
  - state enum {IDLE, SEND}
  - TIMEOUT_CNT_W=16
- Sub-module nf10_rr_pick: combinational rotating priority encoder with inputs req[3:0] and ptr[1:0], and outputs idx[1:0] and any.

Test Plan:
- Reset, then 3-beat packet on s0 only -> IDLE 1 cycle, grant=0, 3 output beats equal to input, tlast on beat 3, pkt_count=1, s1..s3 tready=0 throughout.
- All four inputs continuously valid with 2-beat packets -> grant sequence 0,1,2,3,0; one-cycle gap between packets; pkt_count=5 after 15 cycles.
- m_axis_tready toggled 1,0,0,1 during a 4-beat s2 packet -> source tready mirrors sink ready, no beat lost or duplicated, grant stays 2.
- s1 tvalid drops for 5 cycles mid-packet while s3 is valid -> grant stays 1 until s1 tlast, then s3 is served.
- aresetn low for 1 cycle on beat 2 of a 4-beat s0 packet -> next cycle busy=0, pkt_count=0, all tready=0; s0 is re-granted afterwards.
- With AXIS_REC_ARB_TIMEOUT_EN and C_TIMEOUT_CYCLES=8: stall sink for 8 cycles in SEND -> timeout_err=1 and it stays high after traffic resumes. Without the macro -> timeout_err=0.

Source files
------------

// File: rtl/nf10_axis_rec_arb_pkg.sv
// -----------------------------------------------------------------------------
// nf10_axis_rec_arb_pkg
//   Shared constants and types for the four-input AXI4-Stream packet arbiter.
//   NUM_PORTS     : number of arbitrated input streams
//   PORT_IDX_W    : width of a port index (grant, round-robin pointer)
//   arb_state_e   : arbiter FSM encoding (IDLE = arbitrate, SEND = forward)
//   TIMEOUT_CNT_W : width of the optional stall watchdog counter
// -----------------------------------------------------------------------------
package nf10_axis_rec_arb_pkg;

  localparam int NUM_PORTS     = 4;
  localparam int PORT_IDX_W    = 2;
  localparam int TIMEOUT_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/nf10_rr_pick.sv
// -----------------------------------------------------------------------------
// nf10_rr_pick
//   Combinational rotating priority encoder. Scans req starting at ptr and
//   wrapping modulo NUM_PORTS; idx is the first requester found.
//   req [3:0] : request vector (one bit per input stream)
//   ptr [1:0] : highest-priority index for this arbitration
//   idx [1:0] : selected index (equals ptr when nothing is requesting)
//   any       : at least one request is present
// -----------------------------------------------------------------------------
module nf10_rr_pick
  import nf10_axis_rec_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic [PORT_IDX_W-1:0] idx,
  output logic                  any
);

  logic [PORT_IDX_W-1:0] cand;

  // Walk the offsets from farthest to nearest so that the nearest requester
  // (lowest offset from ptr) is the last to write idx and therefore wins.
  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = ptr + PORT_IDX_W'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/nf10_axis_rec_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_axis_rec_arbiter
//   Packet-granular round-robin arbiter sharing one AXI4-Stream sink among four
//   AXI4-Stream masters. A whole packet from the granted input is forwarded
//   combinationally (no data registers); after its tlast beat the arbiter
//   spends one IDLE cycle re-arbitrating with priority rotated past the
//   previous winner.
//
//   Ports
//     aclk, aresetn              : clock, synchronous active-low reset
//     s_axis_N_* (N = 0..3)      : input streams (tdata/tstrb/tuser/tvalid/
//                                  tlast in, tready out)
//     m_axis_*                   : forwarded output stream
//     grant                      : index of the input owning the output
//     busy                       : high while a packet is in flight (SEND)
//     pkt_count                  : packets forwarded, wraps modulo 2^32
//     timeout_err                : sticky stall watchdog flag
//
//   Optional feature: define AXIS_REC_ARB_TIMEOUT_EN to build the stall
//   watchdog. Without it timeout_err is constant 0.
// -----------------------------------------------------------------------------
module nf10_axis_rec_arbiter
  import nf10_axis_rec_arb_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            aclk,
  input  logic                            aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
  input  logic                            s_axis_0_tvalid,
  input  logic                            s_axis_0_tlast,
  output logic                            s_axis_0_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
  input  logic                            s_axis_1_tvalid,
  input  logic                            s_axis_1_tlast,
  output logic                            s_axis_1_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
  input  logic                            s_axis_2_tvalid,
  input  logic                            s_axis_2_tlast,
  output logic                            s_axis_2_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
  input  logic                            s_axis_3_tvalid,
  input  logic                            s_axis_3_tlast,
  output logic                            s_axis_3_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [1:0]                      grant,
  output logic                            busy,
  output logic [31:0]                     pkt_count,
  output logic                            timeout_err
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  // ---------------------------------------------------------------------------
  // Input streams gathered into arrays so the output path is a plain index.
  // ---------------------------------------------------------------------------
  logic [C_AXIS_DATA_WIDTH-1:0]  s_tdata [NUM_PORTS];
  logic [STRB_W-1:0]             s_tstrb [NUM_PORTS];
  logic [C_AXIS_TUSER_WIDTH-1:0] s_tuser [NUM_PORTS];
  logic [NUM_PORTS-1:0]          s_tvalid;
  logic [NUM_PORTS-1:0]          s_tlast;
  logic [NUM_PORTS-1:0]          s_tready;

  assign s_tdata[0] = s_axis_0_tdata;
  assign s_tdata[1] = s_axis_1_tdata;
  assign s_tdata[2] = s_axis_2_tdata;
  assign s_tdata[3] = s_axis_3_tdata;

  assign s_tstrb[0] = s_axis_0_tstrb;
  assign s_tstrb[1] = s_axis_1_tstrb;
  assign s_tstrb[2] = s_axis_2_tstrb;
  assign s_tstrb[3] = s_axis_3_tstrb;

  assign s_tuser[0] = s_axis_0_tuser;
  assign s_tuser[1] = s_axis_1_tuser;
  assign s_tuser[2] = s_axis_2_tuser;
  assign s_tuser[3] = s_axis_3_tuser;

  assign s_tvalid = {s_axis_3_tvalid, s_axis_2_tvalid,
                     s_axis_1_tvalid, s_axis_0_tvalid};
  assign s_tlast  = {s_axis_3_tlast, s_axis_2_tlast,
                     s_axis_1_tlast, s_axis_0_tlast};

  assign s_axis_0_tready = s_tready[0];
  assign s_axis_1_tready = s_tready[1];
  assign s_axis_2_tready = s_tready[2];
  assign s_axis_3_tready = s_tready[3];

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  logic [0:0]            state;
  logic [PORT_IDX_W-1:0] rr_ptr;
  logic [PORT_IDX_W-1:0] grant_q;
  logic [31:0]           pkt_count_q;

  logic [PORT_IDX_W-1:0] pick_idx;
  logic                  pick_any;
  logic                  sending;
  logic                  xfer;

  nf10_rr_pick u_pick (
    .req (s_tvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sending = (state == ST_SEND);

  // ---------------------------------------------------------------------------
  // Zero-latency pass-through from the granted input. There are no data
  // registers on this path, so there is nothing in it to reset; tvalid is
  // gated by the state so idle-cycle data is never seen as a beat.
  // ---------------------------------------------------------------------------
  assign m_axis_tdata  = s_tdata[grant_q];
  assign m_axis_tstrb  = s_tstrb[grant_q];
  assign m_axis_tuser  = s_tuser[grant_q];
  assign m_axis_tlast  = s_tlast[grant_q];
  assign m_axis_tvalid = sending & s_tvalid[grant_q];

  // Only the granted source sees the sink's ready, and only while sending.
  always_comb begin
    s_tready = '0;
    if (sending) begin
      s_tready[grant_q] = m_axis_tready;
    end
  end

  assign xfer = m_axis_tvalid & m_axis_tready;

  // The grant is latched once per packet and held through SEND, so a source
  // that drops tvalid mid-packet keeps ownership until its tlast beat.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer && m_axis_tlast) begin
            state       <= ST_IDLE;
            rr_ptr      <= grant_q + 1'b1;
            pkt_count_q <= pkt_count_q + 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = sending;
  assign pkt_count = pkt_count_q;

  // ---------------------------------------------------------------------------
  // Optional stall watchdog: counts consecutive SEND cycles without a beat.
  // The flag is sticky until reset and has no effect on arbitration.
  // ---------------------------------------------------------------------------
`ifdef AXIS_REC_ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] stall_cnt;
  logic                     timeout_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (!sending || xfer) begin
      stall_cnt <= '0;
    end else begin
      // Saturate rather than wrap so a very long stall cannot look short.
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (({16'd0, stall_cnt} + 32'd1) >= 32'(C_TIMEOUT_CYCLES)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(C_TIMEOUT_CYCLES);
  assign timeout_err        = 1'b0;
`endif

endmodule
